mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
Memory-mapped console and exit device. It is the responder on the core's data-memory port, and sits beside the unified memory. Stores into its 16-byte window are claimed and serialised out of an 8N1 UART transmitter through a TX FIFO. Loads from the window return status and a free-running cycle counter. A store to the EXIT register raises a sticky exit request with an exit code, for testbench termination.

Parameters:
BASE_ADDR, 32'hFFFF_0000, byte base of the 16-byte register window (16-byte aligned)
FIFO_DEPTH, 8, TX FIFO entries; power of 2, minimum 2
CLKS_PER_BIT, 16, clk cycles per UART bit; minimum 2

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high
addr_read  input  32  data-port read byte address
read_data  output  32  combinational read data; 0 when not hit
hit_read  output  1  combinational; addr_read is inside the window
write_en  input  1  data-port store strobe, active high
write_width  input  4  1 = byte, 2 = half, 4 = word
addr_write  input  32  data-port store byte address
write_data  input  32  store data
hit_write  output  1  combinational; write_en and addr_write inside the window (top uses it to block the memory write)
tx  output  1  UART serial out, registered, idle high
exit_req  output  1  sticky exit request, registered
exit_code  output  8  latched exit code, registered

Behaviour:
- Reset values: tx=1, exit_req=0, exit_code=0, FIFO empty, overflow=0, cycle counter=0, FSM=IDLE.
- Window decode: the address is in the window when addr[31:4]==BASE_ADDR[31:4]. Register offset = addr[3:0].
  - Offsets that are not word aligned (addr[1:0]!=0) count as hits. Writes to them are ignored; reads return 0.
- Registers:
  - 0x0 TXDATA, write-only. A store pushes write_data[7:0] for any write_width. Reads return 0.
  - 0x4 STATUS. Read fields: bit0 busy (FSM!=IDLE), bit1 fifo_full, bit2 fifo_empty, bit3 overflow (sticky). All other bits are 0. A write with write_data[3]=1 clears overflow.
  - 0x8 CYCLE, read-only. 32-bit counter: +1 every non-reset cycle, wraps 32'hFFFF_FFFF to 0. Reads return the current register value. Writes are ignored.
  - 0xC EXIT. A write sets exit_req=1 and exit_code=write_data[7:0] on the same edge. Later EXIT writes update exit_code only. Reads return {23'b0, exit_req, exit_code}.
- FIFO push:
  - A push is accepted when the FIFO is not full, or when a pop happens on the same edge.
  - Otherwise the byte is dropped and overflow is set.
  - Pointers wrap modulo FIFO_DEPTH. The count is held in clog2(FIFO_DEPTH)+1 bits.
- TX FSM: IDLE, START, DATA, STOP, plus a bit-timer (0..CLKS_PER_BIT-1) and a bit index (0..7).
  - IDLE: when the FIFO is non-empty, pop into the shift register, go to START, tx<=0.
  - START: after CLKS_PER_BIT cycles, go to DATA, tx<=bit0.
  - DATA: send LSB first, each bit lasting CLKS_PER_BIT cycles. After bit7, go to STOP with tx<=1.
  - STOP: lasts CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go straight to START (no idle gap). Otherwise go to IDLE.
- Latency: a TXDATA store on edge k into an idle, empty device gives tx falling after edge k+1. A frame is 10*CLKS_PER_BIT cycles.
- Simultaneous push to a full FIFO and FSM pop: the push is accepted and the count is unchanged.
- Reset mid-frame aborts the frame: tx=1 immediately after the reset edge and the FIFO is flushed.
- Both ports may hit in the same cycle. The read is combinational and reflects pre-edge state.

Optional Feature:
MMIO_UART_PARITY_EN
- Defined: an even-parity bit (XOR of the 8 data bits) is inserted between bit7 and STOP as state PARITY, lasting CLKS_PER_BIT cycles. The frame is 11*CLKS_PER_BIT cycles. STATUS bit4 reads 1.
- Undefined: no PARITY state, frame is 10*CLKS_PER_BIT cycles, STATUS bit4 reads 0.

Test Plan:
- Reset, then read BASE+0x4 and BASE+0x8 at the same edge count -> STATUS=32'h4. The next-cycle CYCLE read exceeds the first by 1. tx=1 and exit_req=0 throughout.
- Byte store 8'hA5 to BASE+0x0 with CLKS_PER_BIT=16 -> tx low 16 cycles, then bits 1,0,1,0,0,1,0,1 each 16 cycles, then high. Busy is 1 for 160 cycles.
- Word stores 8'h41,8'h42,8'h43 back-to-back -> three contiguous frames with no idle gap between stop and start; STATUS bit2 returns to 1 afterwards.
- Ten stores in consecutive cycles with FIFO_DEPTH=8 -> exactly 9 bytes sent (the first is popped at edge k+1) and STATUS bit3=1. Writing 32'h8 to STATUS clears overflow.
- Word store 32'h0000_012A to BASE+0xC -> exit_req=1, exit_code=8'h2A on the next edge. hit_write=1 in that cycle. A store to BASE+0x10 gives hit_write=0.
- Reset asserted mid-DATA -> tx=1 after the reset edge, FIFO empty, no further frame output.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped console/exit device: stores to TXDATA feed an 8N1 UART transmitter through a TX FIFO.
// Define MMIO_UART_PARITY_EN to insert an even-parity bit before the stop bit.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr_read,
    output logic [31:0] read_data,
    output logic        hit_read,
    input  logic        write_en,
    input  logic [3:0]  write_width,
    input  logic [31:0] addr_write,
    input  logic [31:0] write_data,
    output logic        hit_write,
    output logic        tx,
    output logic        exit_req,
    output logic [7:0]  exit_code
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
`ifdef MMIO_UART_PARITY_EN
    localparam logic PARITY_FLAG = 1'b1;
`else
    localparam logic PARITY_FLAG = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef MMIO_UART_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    // Window decode; unaligned offsets hit but are inert
    logic wr_aligned, push_req, status_wr, exit_wr;
    assign hit_read   = (addr_read[31:4] == BASE_ADDR[31:4]);
    assign hit_write  = write_en && (addr_write[31:4] == BASE_ADDR[31:4]);
    assign wr_aligned = hit_write && (addr_write[1:0] == 2'b00);
    assign push_req   = wr_aligned && (addr_write[3:2] == 2'd0);
    assign status_wr  = wr_aligned && (addr_write[3:2] == 2'd1);
    assign exit_wr    = wr_aligned && (addr_write[3:2] == 2'd3);

    logic unused_bits;
    assign unused_bits = ^{write_width, write_data[31:8]};

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_full, fifo_empty, pop_c, push_ok;
    logic             overflow;
    logic [31:0]      cycle_cnt;

    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    // A full FIFO still takes the byte when the transmitter pops on the same edge
    assign push_ok    = push_req && (!fifo_full || pop_c);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)   rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= write_data[7:0];
    end

    // Status, cycle counter and exit registers
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            cycle_cnt <= '0;
            exit_req  <= 1'b0;
            exit_code <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (push_req && !push_ok)         overflow <= 1'b1;
            else if (status_wr && write_data[3]) overflow <= 1'b0;
            if (exit_wr) begin
                exit_req  <= 1'b1;
                exit_code <= write_data[7:0];
            end
        end
    end

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_d, bit_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx      <= 1'b1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx      <= tx_d;
        end
    end

    // Transmit sequencing: tx is registered, so each branch sets the level of the next bit
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        tx_d     = tx;
        pop_c    = 1'b0;
        bit_done = (timer_q == TMR_LAST);
        if (state_q != ST_IDLE) timer_d = bit_done ? '0 : timer_q + TMR_W'(1);
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop_c   = 1'b1;
                    shift_d = fifo_mem[rd_ptr];
                    state_d = ST_START;
                    timer_d = '0;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    if (idx_q == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = ^shift_q;
`else
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = shift_q[idx_q + 3'd1];
                    end
                end
            end
`ifdef MMIO_UART_PARITY_EN
            ST_PARITY: begin
                if (bit_done) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (bit_done) begin
                    if (!fifo_empty) begin
                        pop_c   = 1'b1;
                        shift_d = fifo_mem[rd_ptr];
                        state_d = ST_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Combinational read port, reflects pre-edge state
    always_comb begin
        read_data = '0;
        if (hit_read && (addr_read[1:0] == 2'b00)) begin
            case (addr_read[3:2])
                2'd1:    read_data = {27'b0, PARITY_FLAG, overflow, fifo_empty, fifo_full,
                                      (state_q != ST_IDLE)};
                2'd2:    read_data = cycle_cnt;
                2'd3:    read_data = {23'b0, exit_req, exit_code};
                default: read_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: a behavioural UART receiver decodes tx and tests compare
// against bytes and timings predicted from the device's documented behaviour.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE  = 32'hFFFF_0000;
    localparam int          DEPTH = 8;
    localparam int          CPB   = 16;
`ifdef MMIO_UART_PARITY_EN
    localparam int          NBITS    = 11;
    localparam logic [31:0] PAR_STAT = 32'h10;
`else
    localparam int          NBITS    = 10;
    localparam logic [31:0] PAR_STAT = 32'h0;
`endif
    localparam int          FRAME    = NBITS * CPB;
    localparam logic [31:0] ST_IDLE_EMPTY = 32'h4 | PAR_STAT;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr_read = '0;
    logic [31:0] read_data;
    logic        hit_read;
    logic        write_en = 1'b0;
    logic [3:0]  write_width = '0;
    logic [31:0] addr_write = '0;
    logic [31:0] write_data = '0;
    logic        hit_write;
    logic        tx;
    logic        exit_req;
    logic [7:0]  exit_code;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    mmio_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset),
        .addr_read(addr_read), .read_data(read_data), .hit_read(hit_read),
        .write_en(write_en), .write_width(write_width), .addr_write(addr_write),
        .write_data(write_data), .hit_write(hit_write),
        .tx(tx), .exit_req(exit_req), .exit_code(exit_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Receiver: samples each bit mid-period, records decoded bytes and start-bit cycles
    logic [7:0] rx_q[$];
    int         rx_start_q[$];
    int         rx_frame_err = 0;

    initial begin : uart_rx
        int         cnt;
        int         j;
        logic       active;
        logic [7:0] sh;
        active = 1'b0;
        cnt = 0;
        sh = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                active = 1'b0;
            end else if (!active) begin
                if (tx === 1'b0) begin
                    active = 1'b1;
                    cnt = 0;
                    rx_start_q.push_back(cyc);
                end
            end else begin
                cnt++;
                if (cnt % CPB == CPB / 2) begin
                    j = cnt / CPB;
                    if (j == 0) begin
                        if (tx !== 1'b0) rx_frame_err++;
                    end else if (j <= 8) begin
                        sh[j-1] = tx;
                    end else if (j < NBITS - 1) begin
                        if (tx !== ^sh) rx_frame_err++;
                    end else begin
                        if (tx !== 1'b1) rx_frame_err++;
                        rx_q.push_back(sh);
                        active = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // One store cycle starting at a falling edge; returns after the capturing rising edge
    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w,
                         output logic hw);
        write_en = 1'b1;
        addr_write = a;
        write_data = d;
        write_width = w;
        #1;
        hw = hit_write;
        @(negedge clk);
        write_en = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr_read = a;
        #1;
        d = read_data;
    endtask

    task automatic wait_rx(input int n, input int limit);
        int t;
        t = 0;
        while (rx_q.size() < n && t < limit) begin
            @(negedge clk);
            t++;
        end
    endtask

    function automatic logic [3:0] rand_width();
        case ($urandom_range(0, 2))
            0:       return 4'd1;
            1:       return 4'd2;
            default: return 4'd4;
        endcase
    endfunction

    task automatic test_reset();
        logic [31:0] d, c1, c2;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", tx); end
        total++; if (exit_req !== 1'b0 || exit_code !== 8'h00) begin
            bad++; $display("FAIL reset_exit: got req=%b code=%h want 0/00", exit_req, exit_code); end
        reset = 1'b0;
        rd(BASE + 32'h4, d);
        total++; if (d !== ST_IDLE_EMPTY || hit_read !== 1'b1) begin
            bad++; $display("FAIL reset_status: got %h hit=%b want %h hit=1", d, hit_read, ST_IDLE_EMPTY); end
        rd(BASE + 32'h8, c1);
        total++; if (c1 !== 32'd0) begin bad++; $display("FAIL reset_cycle: got %0d want 0", c1); end
        @(negedge clk);
        rd(BASE + 32'h8, c2);
        total++; if (c2 !== c1 + 32'd1) begin bad++; $display("FAIL cycle_incr: got %0d want %0d", c2, c1 + 32'd1); end
        rd(BASE + 32'h2, d);
        total++; if (d !== 32'd0 || hit_read !== 1'b1) begin
            bad++; $display("FAIL unaligned_read: got %h hit=%b want 0 hit=1", d, hit_read); end
        rd(BASE + 32'h10, d);
        total++; if (d !== 32'd0 || hit_read !== 1'b0) begin
            bad++; $display("FAIL outside_read: got %h hit=%b want 0 hit=0", d, hit_read); end
        total++; if (tx !== 1'b1 || exit_req !== 1'b0) begin
            bad++; $display("FAIL post_reset_idle: got tx=%b req=%b want 1/0", tx, exit_req); end
    endtask

    task automatic test_single_byte();
        logic [7:0] b;
        logic       fb [NBITS];
        logic       hw, eb;
        int         k;
        b = 8'hA5;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[i+1] = b[i];
        if (NBITS == 11) fb[9] = ^b;
        fb[NBITS-1] = 1'b1;
        rx_q.delete(); rx_start_q.delete();
        addr_read = BASE + 32'h4;
        store(BASE, {24'($urandom), b}, 4'd1, hw);
        k = cyc;
        total++; if (hw !== 1'b1) begin bad++; $display("FAIL txdata_hit: got %b want 1", hw); end
        for (int c = 1; c <= FRAME + CPB; c++) begin
            @(negedge clk);
            eb = (c <= FRAME) ? fb[(c-1)/CPB] : 1'b1;
            total++; if (tx !== eb) begin bad++; $display("FAIL a5_tx c=%0d: got %b want %b", c, tx, eb); end
            total++; if (read_data[0] !== (c <= FRAME)) begin
                bad++; $display("FAIL a5_busy c=%0d: got %b want %b", c, read_data[0], c <= FRAME); end
        end
        total++; if (rx_q.size() != 1 || rx_start_q.size() != 1) begin
            bad++; $display("FAIL a5_count: got %0d frames want 1", rx_q.size());
        end else begin
            total++; if (rx_q[0] !== b) begin bad++; $display("FAIL a5_byte: got %h want %h", rx_q[0], b); end
            total++; if (rx_start_q[0] != k + 1) begin
                bad++; $display("FAIL a5_latency: got start %0d want %0d", rx_start_q[0], k + 1); end
        end
    endtask

    // Consecutive stores of bytes that all fit; frames must be contiguous
    task automatic run_burst(input logic [7:0] bytes[$], input string name);
        logic        hw;
        logic [31:0] d;
        int          k;
        rx_q.delete(); rx_start_q.delete();
        foreach (bytes[i]) begin
            store(BASE, {24'($urandom), bytes[i]}, rand_width(), hw);
            if (i == 0) k = cyc;
        end
        wait_rx(bytes.size(), (bytes.size() + 1) * FRAME);
        total++; if (rx_q.size() != bytes.size()) begin
            bad++; $display("FAIL %s_count: got %0d want %0d", name, rx_q.size(), bytes.size());
        end else begin
            foreach (bytes[i]) begin
                total++; if (rx_q[i] !== bytes[i]) begin
                    bad++; $display("FAIL %s_byte%0d: got %h want %h", name, i, rx_q[i], bytes[i]); end
                total++; if (rx_start_q[i] != k + 1 + i * FRAME) begin
                    bad++; $display("FAIL %s_start%0d: got %0d want %0d", name, i, rx_start_q[i], k + 1 + i * FRAME); end
            end
        end
        repeat (CPB) @(negedge clk);
        rd(BASE + 32'h4, d);
        total++; if (d !== ST_IDLE_EMPTY) begin bad++; $display("FAIL %s_status_after: got %h want %h", name, d, ST_IDLE_EMPTY); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes[$];
        bytes = '{8'h41, 8'h42, 8'h43};
        run_burst(bytes, "b2b");
    endtask

    task automatic test_random_frames();
        logic [7:0] bytes[$];
        for (int r = 0; r < 3; r++) begin
            bytes.delete();
            for (int i = 0; i < int'($urandom_range(1, 5)); i++) bytes.push_back(8'($urandom));
            run_burst(bytes, "rand");
        end
    endtask

    task automatic test_overflow();
        localparam int N = 10;
        logic [7:0]  din [N];
        logic [7:0]  q[$];
        logic [7:0]  exp_q[$];
        logic [31:0] d;
        logic        hw, pop_now, acc, exp_ovf;
        exp_ovf = 1'b0;
        for (int i = 0; i < N; i++) din[i] = 8'($urandom);
        // Queue model: byte i lands on edge k+i; the idle transmitter takes the head at edge k+1
        for (int i = 0; i < N; i++) begin
            pop_now = (i == 1);
            acc = (q.size() < DEPTH) || pop_now;
            if (pop_now) exp_q.push_back(q.pop_front());
            if (acc) q.push_back(din[i]); else exp_ovf = 1'b1;
        end
        while (q.size() > 0) exp_q.push_back(q.pop_front());
        rx_q.delete(); rx_start_q.delete();
        for (int i = 0; i < N; i++) store(BASE, {24'($urandom), din[i]}, rand_width(), hw);
        rd(BASE + 32'h4, d);
        total++; if (d[3] !== exp_ovf || d[1] !== 1'b1) begin
            bad++; $display("FAIL ovf_set: got ovf=%b full=%b want %b/1", d[3], d[1], exp_ovf); end
        store(BASE + 32'h4, 32'hFFFF_FFF7, 4'd4, hw);
        rd(BASE + 32'h4, d);
        total++; if (d[3] !== exp_ovf) begin bad++; $display("FAIL ovf_keep: got %b want %b", d[3], exp_ovf); end
        store(BASE + 32'h4, 32'h0000_0008, 4'd4, hw);
        rd(BASE + 32'h4, d);
        total++; if (d[3] !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", d[3]); end
        wait_rx(exp_q.size(), (exp_q.size() + 1) * FRAME);
        repeat (FRAME) @(negedge clk);
        total++; if (rx_q.size() != exp_q.size()) begin
            bad++; $display("FAIL ovf_count: got %0d want %0d", rx_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                total++; if (rx_q[i] !== exp_q[i]) begin
                    bad++; $display("FAIL ovf_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
            end
        end
        total++; if (rx_frame_err != 0) begin bad++; $display("FAIL frame_errors: got %0d want 0", rx_frame_err); end
    endtask

    task automatic test_exit();
        logic        hw;
        logic [31:0] d;
        logic [7:0]  code2;
        store(BASE + 32'hC, 32'h0000_012A, 4'd4, hw);
        total++; if (hw !== 1'b1) begin bad++; $display("FAIL exit_hit: got %b want 1", hw); end
        total++; if (exit_req !== 1'b1 || exit_code !== 8'h2A) begin
            bad++; $display("FAIL exit_set: got req=%b code=%h want 1/2a", exit_req, exit_code); end
        rd(BASE + 32'hC, d);
        total++; if (d !== 32'h0000_012A) begin bad++; $display("FAIL exit_read: got %h want 0000012a", d); end
        code2 = 8'($urandom);
        store(BASE + 32'hC, {24'($urandom), code2}, 4'd1, hw);
        total++; if (exit_req !== 1'b1 || exit_code !== code2) begin
            bad++; $display("FAIL exit_update: got req=%b code=%h want 1/%h", exit_req, exit_code, code2); end
        store(BASE + 32'h10, 32'h0000_0077, 4'd4, hw);
        total++; if (hw !== 1'b0 || exit_code !== code2) begin
            bad++; $display("FAIL outside_write: got hit=%b code=%h want 0/%h", hw, exit_code, code2); end
        store(BASE + 32'hD, 32'h0000_0055, 4'd1, hw);
        total++; if (hw !== 1'b1 || exit_code !== code2) begin
            bad++; $display("FAIL unaligned_exit: got hit=%b code=%h want 1/%h", hw, exit_code, code2); end
        store(BASE + 32'h1, 32'h0000_0066, 4'd1, hw);
        @(negedge clk);
        rd(BASE + 32'h4, d);
        total++; if (hw !== 1'b1 || d !== ST_IDLE_EMPTY) begin
            bad++; $display("FAIL unaligned_tx: got hit=%b status=%h want 1/%h", hw, d, ST_IDLE_EMPTY); end
        write_en = 1'b0; addr_write = BASE + 32'hC; #1;
        total++; if (hit_write !== 1'b0) begin bad++; $display("FAIL no_strobe_hit: got %b want 0", hit_write); end
    endtask

    task automatic test_reset_mid();
        logic        hw;
        logic [31:0] d;
        int          starts, lows;
        store(BASE, {24'($urandom), 8'($urandom)}, 4'd4, hw);
        store(BASE, {24'($urandom), 8'($urandom)}, 4'd4, hw);
        repeat (4 * CPB + 5) @(negedge clk);
        rd(BASE + 32'h4, d);
        total++; if (d[0] !== 1'b1 || d[2] !== 1'b0) begin
            bad++; $display("FAIL mid_busy: got busy=%b empty=%b want 1/0", d[0], d[2]); end
        starts = rx_start_q.size();
        reset = 1'b1;
        @(negedge clk);
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL mid_reset_tx: got %b want 1", tx); end
        reset = 1'b0;
        rd(BASE + 32'h4, d);
        total++; if (d !== ST_IDLE_EMPTY || exit_req !== 1'b0) begin
            bad++; $display("FAIL mid_reset_state: got %h req=%b want %h/0", d, exit_req, ST_IDLE_EMPTY); end
        lows = 0;
        repeat (3 * FRAME) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        total++; if (lows != 0 || rx_start_q.size() != starts) begin
            bad++; $display("FAIL mid_reset_quiet: got %0d low cycles %0d new frames want 0/0", lows, rx_start_q.size() - starts); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_random_frames();
        test_overflow();
        test_exit();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
